// File: rtl/q_agent_ctrl.sv
// Episode controller for a tabular Q-learning agent: scans a Q-table row, picks an
// epsilon-greedy action, queries the environment and issues one update per step.
module q_agent_ctrl #(
    parameter int unsigned NUM_ACT    = 15,
    parameter int unsigned MAX_STEPS  = 64,
    parameter int unsigned UPD_CYCLES = 3,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [5:0]         init_state,
    input  logic [5:0]         goal_state,
    input  logic [3:0]         epsilon,
    output logic [5:0]         q_rd_state,
    output logic [3:0]         q_rd_act,
    input  logic signed [15:0] q_rd_data,
    output logic               env_req,
    output logic [3:0]         env_action,
    input  logic               env_valid,
    input  logic [5:0]         env_next_state,
    input  logic signed [15:0] env_reward,
    output logic               acc_en,
    output logic [5:0]         acc_state,
    output logic [5:0]         acc_next_state,
    output logic [3:0]         acc_action,
    output logic [15:0]        acc_reward,
    output logic               busy,
    output logic               done,
    output logic [6:0]         step_cnt,
    output logic [15:0]        total_reward
);

    localparam int unsigned UPD_W     = (UPD_CYCLES > 1) ? $clog2(UPD_CYCLES) : 1;
    localparam logic [UPD_W-1:0] UPD_LAST = UPD_W'(UPD_CYCLES - 1);
    localparam logic [3:0] SCAN_LAST  = 4'(NUM_ACT);
    localparam logic [6:0] STEP_LIMIT = 7'(MAX_STEPS);
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        StIdle,
        StScan,
        StChoose,
        StEnvReq,
        StWaitEnv,
        StUpdate,
        StCheck
    } state_e;

    state_e             state_q, state_d;
    logic [5:0]         cur_state_q, cur_state_d;
    logic [3:0]         scan_cnt_q, scan_cnt_d;
    logic signed [15:0] best_val_q, best_val_d;
    logic [3:0]         best_act_q, best_act_d;
    logic [3:0]         act_q, act_d;
    logic [5:0]         next_q, next_d;
    logic [15:0]        rew_q, rew_d;
    logic [UPD_W-1:0]   upd_cnt_q, upd_cnt_d;
    logic [6:0]         step_q, step_d;
    logic [15:0]        total_q, total_d;
    logic               done_q, done_d;
    logic [15:0]        lfsr_q, lfsr_d;

    logic       explore;
    logic [3:0] explore_act;

    assign explore     = lfsr_q[7:4] < epsilon;
    assign explore_act = 4'((32'(lfsr_q[3:0]) % NUM_ACT) + 32'd1);

    always_comb begin
        state_d     = state_q;
        cur_state_d = cur_state_q;
        scan_cnt_d  = scan_cnt_q;
        best_val_d  = best_val_q;
        best_act_d  = best_act_q;
        act_d       = act_q;
        next_d      = next_q;
        rew_d       = rew_q;
        upd_cnt_d   = upd_cnt_q;
        step_d      = step_q;
        total_d     = total_q;
        done_d      = 1'b0;
        lfsr_d      = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);

        q_rd_state     = '0;
        q_rd_act       = '0;
        env_req        = 1'b0;
        env_action     = '0;
        acc_en         = 1'b0;
        acc_state      = '0;
        acc_next_state = '0;
        acc_action     = '0;
        acc_reward     = '0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    cur_state_d = init_state;
                    step_d      = '0;
                    total_d     = '0;
                    scan_cnt_d  = '0;
                    state_d     = StScan;
                end
            end
            StScan: begin
                q_rd_state = cur_state_q;
                if (scan_cnt_q < SCAN_LAST) begin
                    q_rd_act = scan_cnt_q + 4'd1;
                end
                // Data seen with count c belongs to action c; strict > keeps the lowest index.
                if (scan_cnt_q != 4'd0) begin
                    if (scan_cnt_q == 4'd1 || q_rd_data > best_val_q) begin
                        best_val_d = q_rd_data;
                        best_act_d = scan_cnt_q;
                    end
                end
                if (scan_cnt_q == SCAN_LAST) begin
                    state_d = StChoose;
                end else begin
                    scan_cnt_d = scan_cnt_q + 4'd1;
                end
            end
            StChoose: begin
                act_d   = explore ? explore_act : best_act_q;
                state_d = StEnvReq;
            end
            StEnvReq: begin
                env_req    = 1'b1;
                env_action = act_q;
                state_d    = StWaitEnv;
            end
            StWaitEnv: begin
                env_action = act_q;
                if (env_valid) begin
                    next_d    = env_next_state;
                    rew_d     = env_reward;
                    upd_cnt_d = '0;
                    state_d   = StUpdate;
                end
            end
            StUpdate: begin
                acc_en         = 1'b1;
                acc_state      = cur_state_q;
                acc_next_state = next_q;
                acc_action     = act_q;
                acc_reward     = rew_q;
                if (upd_cnt_q == UPD_LAST) begin
                    state_d = StCheck;
                end else begin
                    upd_cnt_d = upd_cnt_q + 1'b1;
                end
            end
            StCheck: begin
                step_d      = step_q + 7'd1;
                total_d     = total_q + rew_q;
                cur_state_d = next_q;
                if (next_q == goal_state || step_d == STEP_LIMIT) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    scan_cnt_d = '0;
                    state_d    = StScan;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cur_state_q <= '0;
            scan_cnt_q  <= '0;
            best_val_q  <= '0;
            best_act_q  <= '0;
            act_q       <= '0;
            next_q      <= '0;
            rew_q       <= '0;
            upd_cnt_q   <= '0;
            step_q      <= '0;
            total_q     <= '0;
            done_q      <= 1'b0;
            lfsr_q      <= LFSR_SEED;
        end else begin
            state_q     <= state_d;
            cur_state_q <= cur_state_d;
            scan_cnt_q  <= scan_cnt_d;
            best_val_q  <= best_val_d;
            best_act_q  <= best_act_d;
            act_q       <= act_d;
            next_q      <= next_d;
            rew_q       <= rew_d;
            upd_cnt_q   <= upd_cnt_d;
            step_q      <= step_d;
            total_q     <= total_d;
            done_q      <= done_d;
            lfsr_q      <= lfsr_d;
        end
    end

    // done is registered so it coincides with the final step_cnt/total_reward.
    assign done         = done_q;
    assign busy         = (state_q != StIdle);
    assign step_cnt     = step_q;
    assign total_reward = total_q;

    a_lfsr_nonzero: assert property (@(posedge clk) disable iff (rst) lfsr_q != 16'h0);
    a_req_pulse:    assert property (@(posedge clk) disable iff (rst) env_req |=> !env_req);
    a_done_pulse:   assert property (@(posedge clk) disable iff (rst) done |=> !done);

endmodule

// File: tb/tb_q_agent_ctrl.sv
// Directed bench for q_agent_ctrl: Q-table and environment models plus an LFSR reference.
module tb_q_agent_ctrl;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic [5:0]         init_state = '0;
    logic [5:0]         goal_state = '0;
    logic [3:0]         epsilon = '0;
    logic [5:0]         q_rd_state;
    logic [3:0]         q_rd_act;
    logic signed [15:0] q_rd_data = '0;
    logic               env_req;
    logic [3:0]         env_action;
    logic               env_valid = 1'b0;
    logic [5:0]         env_next_state = '0;
    logic signed [15:0] env_reward = '0;
    logic               acc_en;
    logic [5:0]         acc_state;
    logic [5:0]         acc_next_state;
    logic [3:0]         acc_action;
    logic [15:0]        acc_reward;
    logic               busy;
    logic               done;
    logic [6:0]         step_cnt;
    logic [15:0]        total_reward;

    int tests_run = 0;
    int tests_failed = 0;

    q_agent_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .init_state    (init_state),
        .goal_state    (goal_state),
        .epsilon       (epsilon),
        .q_rd_state    (q_rd_state),
        .q_rd_act      (q_rd_act),
        .q_rd_data     (q_rd_data),
        .env_req       (env_req),
        .env_action    (env_action),
        .env_valid     (env_valid),
        .env_next_state(env_next_state),
        .env_reward    (env_reward),
        .acc_en        (acc_en),
        .acc_state     (acc_state),
        .acc_next_state(acc_next_state),
        .acc_action    (acc_action),
        .acc_reward    (acc_reward),
        .busy          (busy),
        .done          (done),
        .step_cnt      (step_cnt),
        .total_reward  (total_reward)
    );

    always #5 clk = ~clk;

    // Q-table with one cycle read latency.
    logic signed [15:0] q_mem [64][16];
    always @(posedge clk) q_rd_data <= q_mem[q_rd_state][q_rd_act];

    // Reference LFSR; m_prev holds the value of the previous cycle.
    logic [15:0] m_lfsr, m_prev;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lfsr <= 16'hACE1;
            m_prev <= 16'hACE1;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
        end
    end

    int         ep_reqs, ep_acc, ep_bad, ep_act_err, ep_lfsr_zero;
    logic [3:0] ep_act;
    logic       ep_done;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic fill_row(input int s, input logic signed [15:0] v);
        for (int a = 0; a < 16; a++) q_mem[s][a] = v;
    endtask

    // Runs one episode with a fixed environment response; optionally asserts rst
    // once acc_en has been seen rst_at_acc times.
    task automatic run_episode(input logic [5:0] init, input logic [5:0] goal,
                               input logic [3:0] eps, input logic [5:0] nxt,
                               input logic [15:0] rew, input logic [3:0] greedy,
                               input int budget, input int rst_at_acc);
        int         wait_ctr;
        bit         fin;
        logic [3:0] exp_act;
        ep_reqs = 0; ep_acc = 0; ep_bad = 0; ep_act_err = 0; ep_lfsr_zero = 0;
        ep_act = '0; ep_done = 1'b0;
        init_state = init; goal_state = goal; epsilon = eps;
        env_next_state = nxt; env_reward = rew;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_ctr = 0;
        fin = 1'b0;
        for (int c = 0; c < budget && !fin; c++) begin
            env_valid = 1'b0;
            if (wait_ctr != 0) begin
                wait_ctr--;
                if (wait_ctr == 0) env_valid = 1'b1;
            end
            if (env_req) begin
                ep_reqs++;
                ep_act = env_action;
                exp_act = (m_prev[7:4] < eps) ? 4'((m_prev[3:0] % 15) + 1) : greedy;
                if (env_action != exp_act) ep_act_err++;
                if (q_rd_act != 0 || acc_en) ep_bad++;
                wait_ctr = 2;
            end else if ((wait_ctr != 0 || env_valid) && env_action != ep_act) begin
                ep_bad++;
            end
            if (acc_en) begin
                ep_acc++;
                if (acc_action != ep_act || acc_reward != rew || acc_next_state != nxt ||
                    acc_state != ((ep_reqs == 1) ? init : nxt) || env_action != 0 ||
                    q_rd_act != 0)
                    ep_bad++;
            end
            if (dut.lfsr_q == 16'h0) ep_lfsr_zero++;
            if (rst_at_acc != 0 && ep_acc == rst_at_acc) begin
                rst = 1'b1;
                fin = 1'b1;
            end else if (done) begin
                ep_done = 1'b1;
                fin = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        env_valid = 1'b0;
    endtask

    task automatic greedy_case(input string tag, input logic [5:0] s, input logic [3:0] want);
        run_episode(s, 6'd40, 4'd0, 6'd40, 16'd5, want, 200, 0);
        check_val({tag, "_act"}, 32'(ep_act), 32'(want));
        check_val({tag, "_done"}, 32'(ep_done), 32'd1);
        check_val({tag, "_acc_cycles"}, ep_acc, 32'd3);
        check_val({tag, "_bad"}, ep_bad, 32'd0);
    endtask

    initial begin
        int tot_err, rng_err, miss, zero_seen, reqs;
        for (int s = 0; s < 64; s++) fill_row(s, 16'sd0);

        // Reset state
        #1 rst = 1'b1;
        env_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_step_cnt", 32'(step_cnt), 32'd0);
        check_val("rst_total", 32'(total_reward), 32'd0);
        check_val("rst_acc", {acc_en, acc_action, acc_state, acc_next_state}, 32'd0);
        check_val("rst_acc_reward", 32'(acc_reward), 32'd0);
        check_val("rst_env_q", {env_req, env_action, q_rd_state, q_rd_act}, 32'd0);
        check_val("rst_lfsr", 32'(dut.lfsr_q), 32'hACE1);
        // A stale env_valid across reset release must not start anything.
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_val("post_rst_idle", {busy, acc_en, env_req}, 32'd0);
        env_valid = 1'b0;

        // Greedy pick: action 7 dominates
        fill_row(2, -16'sd100);
        q_mem[2][7] = 16'sd300;
        greedy_case("greedy7", 6'd2, 4'd7);
        check_val("greedy7_step_cnt", 32'(step_cnt), 32'd1);
        check_val("greedy7_total", 32'(total_reward), 32'd5);

        // Ties resolve to the lowest action
        greedy_case("tie_all0", 6'd3, 4'd1);
        q_mem[4][3] = 16'sd5;
        q_mem[4][9] = 16'sd5;
        greedy_case("tie_3_9", 6'd4, 4'd3);

        // Signed compare and max initialised from the first value
        fill_row(6, -16'sd5);
        q_mem[6][1] = 16'sd100;
        q_mem[6][5] = -16'sd1;
        greedy_case("signed", 6'd6, 4'd1);
        fill_row(7, -16'sd300);
        q_mem[7][15] = -16'sd200;
        greedy_case("all_neg", 6'd7, 4'd15);

        // Goal reached on the first step
        run_episode(6'd0, 6'd12, 4'd0, 6'd12, 16'd100, 4'd1, 200, 0);
        check_val("goal_done", 32'(ep_done), 32'd1);
        check_val("goal_step_cnt", 32'(step_cnt), 32'd1);
        check_val("goal_total", 32'(total_reward), 32'd100);
        check_val("goal_busy_at_done", 32'(busy), 32'd0);
        @(negedge clk);
        check_val("goal_done_pulse", 32'(done), 32'd0);

        // Start already at goal still runs one step
        run_episode(6'd12, 6'd12, 4'd0, 6'd12, 16'd7, 4'd1, 200, 0);
        check_val("init_goal_step_cnt", 32'(step_cnt), 32'd1);
        check_val("init_goal_acc", ep_acc, 32'd3);
        check_val("init_goal_total", 32'(total_reward), 32'd7);

        // Step limit with -1 reward per step
        run_episode(6'd5, 6'd63, 4'd0, 6'd5, 16'hFFFF, 4'd1, 64 * 40 + 100, 0);
        check_val("limit_done", 32'(ep_done), 32'd1);
        check_val("limit_step_cnt", 32'(step_cnt), 32'd64);
        check_val("limit_total", 32'(total_reward), 32'hFFC0);
        check_val("limit_reqs", ep_reqs, 32'd64);
        check_val("limit_acc", ep_acc, 32'd192);
        check_val("limit_bad", ep_bad, 32'd0);

        // Exploration: every action predicted from the reference LFSR
        q_mem[9][7] = 16'sd50;
        tot_err = 0; rng_err = 0; miss = 0; zero_seen = 0; reqs = 0;
        for (int e = 0; e < 1100; e++) begin
            run_episode(6'd9, 6'd0, (e < 1000) ? 4'd15 : 4'd8, 6'd0, 16'd1, 4'd7, 200, 0);
            tot_err += ep_act_err + ep_bad;
            if (ep_act == 4'd0) rng_err++;
            if (!ep_done) miss++;
            zero_seen += ep_lfsr_zero;
            reqs += ep_reqs;
        end
        check_val("explore_act", tot_err, 32'd0);
        check_val("explore_range", rng_err, 32'd0);
        check_val("explore_done", miss, 32'd0);
        check_val("explore_lfsr_nz", zero_seen, 32'd0);
        check_val("explore_reqs", reqs, 32'd1100);

        // Asynchronous reset in the second acc_en cycle
        run_episode(6'd2, 6'd40, 4'd0, 6'd40, 16'd5, 4'd7, 200, 2);
        check_val("mid_rst_reached", ep_acc, 32'd2);
        #1;
        check_val("mid_rst_acc_en", 32'(acc_en), 32'd0);
        check_val("mid_rst_busy", 32'(busy), 32'd0);
        check_val("mid_rst_lfsr", 32'(dut.lfsr_q), 32'hACE1);
        check_val("mid_rst_step_cnt", 32'(step_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        greedy_case("after_rst", 6'd2, 4'd7);
        check_val("after_rst_step_cnt", 32'(step_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
